// File: rtl/rm14_encode_tx.sv
// RM(1,4) encoder/transmitter: takes a 5-bit message and builds its 16-bit codeword,
// then streams the codeword out one bit per valid/ready beat.
//
// state | meaning
// IDLE  | no codeword in flight; ready for a message once out of reset
// SEND  | shifting the codeword out; idx is the beat currently presented
module rm14_encode_tx #(
    parameter bit LSB_FIRST = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       msg_data,
    input  logic             msg_valid,
    output logic             msg_ready,
    output logic             ser_bit,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_first,
    output logic             ser_last,
    output logic [15:0]      cw_data,
    output logic [CNT_W-1:0] cw_count
);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t      state, state_nx;
    logic        armed;
    logic [3:0]  idx;
    logic [15:0] shreg;
    logic [15:0] cw_new;
    logic        beat, last_beat, accept;

    always_comb begin
        cw_new = '0;
        for (int j = 0; j < 16; j++) begin
            cw_new[j] = msg_data[0] ^ (msg_data[1] & j[0]) ^ (msg_data[2] & j[1])
                      ^ (msg_data[3] & j[2]) ^ (msg_data[4] & j[3]);
        end
    end

    assign beat      = (state == SEND) && ser_ready;
    assign last_beat = beat && (idx == 4'd15);
    assign accept    = msg_valid && msg_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = SEND;
            SEND:    if (last_beat && !accept) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // msg_ready opens on the last beat so a waiting message follows with no bubble
    always_comb begin
        msg_ready = armed && ((state == IDLE) || last_beat);
        ser_valid = (state == SEND);
        ser_bit   = 1'b0;
        if (state == SEND) begin
            ser_bit = LSB_FIRST ? shreg[0] : shreg[15];
        end
        ser_first = (state == SEND) && (idx == 4'd0);
        ser_last  = (state == SEND) && (idx == 4'd15);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed    <= 1'b0;
            idx      <= '0;
            shreg    <= '0;
            cw_data  <= '0;
            cw_count <= '0;
        end else begin
            armed <= 1'b1;
            if (last_beat) begin
                cw_count <= cw_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (accept) begin
                shreg   <= cw_new;
                cw_data <= cw_new;
                idx     <= '0;
            end else if (beat) begin
                shreg <= LSB_FIRST ? {1'b0, shreg[15:1]} : {shreg[14:0], 1'b0};
                idx   <= idx + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_rm14_encode_tx.sv
// Bench for rm14_encode_tx: three instances (LSB-first, MSB-first, 4-bit counter) share
// stimulus and are each checked beat-by-beat against a parity-based codeword model.
module tb_rm14_encode_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  msg_data = '0;
    logic        msg_valid = 1'b0;
    logic        ser_ready = 1'b0;

    logic [2:0]  mrdy, sbit, sval, sfirst, slast;
    logic [15:0] cwd [3];
    logic [15:0] c0, c1;
    logic [3:0]  c2;
    logic [15:0] cntv [3];

    int nvec = 0;
    int nmiss = 0;
    int model_cnt = 0;

    always #5 clk = ~clk;

    rm14_encode_tx #(.LSB_FIRST(1'b1), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .msg_data(msg_data), .msg_valid(msg_valid),
        .msg_ready(mrdy[0]), .ser_bit(sbit[0]), .ser_valid(sval[0]), .ser_ready(ser_ready),
        .ser_first(sfirst[0]), .ser_last(slast[0]), .cw_data(cwd[0]), .cw_count(c0));

    rm14_encode_tx #(.LSB_FIRST(1'b0), .CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .msg_data(msg_data), .msg_valid(msg_valid),
        .msg_ready(mrdy[1]), .ser_bit(sbit[1]), .ser_valid(sval[1]), .ser_ready(ser_ready),
        .ser_first(sfirst[1]), .ser_last(slast[1]), .cw_data(cwd[1]), .cw_count(c1));

    rm14_encode_tx #(.LSB_FIRST(1'b1), .CNT_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .msg_data(msg_data), .msg_valid(msg_valid),
        .msg_ready(mrdy[2]), .ser_bit(sbit[2]), .ser_valid(sval[2]), .ser_ready(ser_ready),
        .ser_first(sfirst[2]), .ser_last(slast[2]), .cw_data(cwd[2]), .cw_count(c2));

    always_comb begin
        cntv[0] = c0;
        cntv[1] = c1;
        cntv[2] = {12'b0, c2};
    end

    // codeword bit j is the parity of the message masked by {j, 1}
    function automatic logic [15:0] model_cw(input logic [4:0] m);
        logic [15:0] cw;
        logic [4:0]  sel;
        for (int j = 0; j < 16; j++) begin
            sel   = {j[3:0], 1'b1};
            cw[j] = ^(m & sel);
        end
        return cw;
    endfunction

    function automatic logic [15:0] model_count(input int i);
        return (i == 2) ? 16'(model_cnt % 16) : 16'(model_cnt % 65536);
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        msg_valid = 1'b0;
        ser_ready = 1'b0;
        model_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    // mode 0: ready always 1; 1: ready toggles 1,0,1,0...; 2: random ready
    task automatic run_cw(input logic [4:0] m, input int mode, input bit preloaded,
                          input bit chain, input logic [4:0] mnext, output int cycles);
        logic [15:0] exp;
        logic        eb;
        int          k;
        bit          tog;
        exp    = model_cw(m);
        cycles = 0;
        k      = 0;
        tog    = 1'b1;
        if (!preloaded) begin
            @(negedge clk);
            msg_data  = m;
            msg_valid = 1'b1;
            ser_ready = 1'b0;
            #1;
            for (int i = 0; i < 3; i++) begin
                nvec++;
                if (mrdy[i] !== 1'b1 || sval[i] !== 1'b0) begin
                    nmiss++;
                    $display("FAIL accept dut%0d msg_ready=%b ser_valid=%b required 1/0", i, mrdy[i], sval[i]);
                end
            end
            @(posedge clk);
            cycles = 1;
        end
        while (k < 16 && cycles < 400) begin
            @(negedge clk);
            case (mode)
                0:       ser_ready = 1'b1;
                1:       begin ser_ready = tog; tog = ~tog; end
                default: ser_ready = 1'($urandom_range(0, 1));
            endcase
            msg_valid = 1'b0;
            if (chain && k == 15 && ser_ready) begin
                msg_valid = 1'b1;
                msg_data  = mnext;
            end
            #1;
            for (int i = 0; i < 3; i++) begin
                eb = (i == 1) ? exp[15 - k] : exp[k];
                nvec++;
                if (sval[i] !== 1'b1 || sbit[i] !== eb || sfirst[i] !== (k == 0) ||
                    slast[i] !== (k == 15) || mrdy[i] !== (k == 15 && ser_ready) ||
                    cwd[i] !== exp || cntv[i] !== model_count(i)) begin
                    nmiss++;
                    $display("FAIL beat dut%0d m=%b k=%0d got v=%b b=%b f=%b l=%b rdy=%b cw=%h cnt=%0d required b=%b cw=%h cnt=%0d",
                             i, m, k, sval[i], sbit[i], sfirst[i], slast[i], mrdy[i], cwd[i], cntv[i],
                             eb, exp, model_count(i));
                end
            end
            @(posedge clk);
            cycles++;
            if (ser_ready) begin
                k++;
                if (k == 16) model_cnt++;
            end
        end
        nvec++;
        if (k != 16) begin
            nmiss++;
            $display("FAIL timeout m=%b beats=%0d required 16", m, k);
        end
        if (!chain) begin
            @(negedge clk);
            msg_valid = 1'b0;
            ser_ready = 1'b0;
            #1;
            for (int i = 0; i < 3; i++) begin
                nvec++;
                if (sval[i] !== 1'b0 || mrdy[i] !== 1'b1 || cwd[i] !== exp ||
                    cntv[i] !== model_count(i)) begin
                    nmiss++;
                    $display("FAIL idle dut%0d v=%b rdy=%b cw=%h cnt=%0d required 0/1 cw=%h cnt=%0d",
                             i, sval[i], mrdy[i], cwd[i], cntv[i], exp, model_count(i));
                end
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            nvec++;
            if (mrdy[i] !== 1'b0 || sval[i] !== 1'b0 || sbit[i] !== 1'b0 || sfirst[i] !== 1'b0 ||
                slast[i] !== 1'b0 || cwd[i] !== 16'h0 || cntv[i] !== 16'h0) begin
                nmiss++;
                $display("FAIL reset dut%0d rdy=%b v=%b b=%b f=%b l=%b cw=%h cnt=%0d required all zero",
                         i, mrdy[i], sval[i], sbit[i], sfirst[i], slast[i], cwd[i], cntv[i]);
            end
        end
        apply_reset();
        nvec++;
        if (mrdy !== 3'b000) begin
            nmiss++;
            $display("FAIL release msg_ready=%b required 000 before first clock", mrdy);
        end
        @(negedge clk);
        nvec++;
        if (mrdy !== 3'b111) begin
            nmiss++;
            $display("FAIL armed msg_ready=%b required 111", mrdy);
        end
    endtask

    task automatic test_zero();
        int cyc;
        run_cw(5'b00000, 0, 1'b0, 1'b0, 5'b0, cyc);
    endtask

    task automatic test_rows();
        int cyc;
        logic [4:0] ms [3] = '{5'b00001, 5'b00010, 5'b10000};
        logic [15:0] rows [3] = '{16'hFFFF, 16'hAAAA, 16'hFF00};
        for (int t = 0; t < 3; t++) begin
            run_cw(ms[t], 0, 1'b0, 1'b0, 5'b0, cyc);
            nvec++;
            if (cwd[0] !== rows[t]) begin
                nmiss++;
                $display("FAIL row m=%b cw=%h required %h", ms[t], cwd[0], rows[t]);
            end
        end
    endtask

    task automatic test_msb_stall();
        int cyc;
        run_cw(5'b10101, 1, 1'b0, 1'b0, 5'b0, cyc);
        nvec++;
        if (cwd[1] !== 16'hCC33 || cyc != 32) begin
            nmiss++;
            $display("FAIL msb_stall cw=%h cycles=%0d required CC33 32", cwd[1], cyc);
        end
    endtask

    task automatic test_back_to_back();
        int cyc1, cyc2;
        run_cw(5'b00011, 0, 1'b0, 1'b1, 5'b00100, cyc1);
        run_cw(5'b00100, 0, 1'b1, 1'b0, 5'b0, cyc2);
        nvec++;
        if (cyc1 + cyc2 != 33 || cwd[0] !== 16'hCCCC) begin
            nmiss++;
            $display("FAIL b2b cycles=%0d cw=%h required 33 CCCC", cyc1 + cyc2, cwd[0]);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        @(negedge clk);
        msg_data  = 5'b01000;
        msg_valid = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            msg_valid = 1'b0;
            ser_ready = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        ser_ready = 1'b0;
        #1;
        nvec++;
        if (sval !== 3'b111 || sfirst !== 3'b000) begin
            nmiss++;
            $display("FAIL mid_pre v=%b f=%b required 111 000", sval, sfirst);
        end
        rst_n = 1'b0;
        model_cnt = 0;
        #1;
        for (int i = 0; i < 3; i++) begin
            nvec++;
            if (sval[i] !== 1'b0 || sbit[i] !== 1'b0 || slast[i] !== 1'b0 || mrdy[i] !== 1'b0 ||
                cwd[i] !== 16'h0 || cntv[i] !== 16'h0) begin
                nmiss++;
                $display("FAIL mid_reset dut%0d v=%b b=%b l=%b rdy=%b cw=%h cnt=%0d required all zero",
                         i, sval[i], sbit[i], slast[i], mrdy[i], cwd[i], cntv[i]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_cw(5'b01000, 0, 1'b0, 1'b0, 5'b0, cyc);
        nvec++;
        if (cwd[0] !== 16'hF0F0 || c0 !== 16'd1) begin
            nmiss++;
            $display("FAIL mid_resend cw=%h cnt=%0d required F0F0 1", cwd[0], c0);
        end
    endtask

    task automatic test_wrap();
        int cyc;
        apply_reset();
        @(negedge clk);
        for (int m = 0; m < 32; m++) begin
            run_cw(5'(m), 2, 1'b0, 1'b0, 5'b0, cyc);
        end
        nvec++;
        if (c2 !== 4'd0 || c0 !== 16'd32) begin
            nmiss++;
            $display("FAIL wrap cnt4=%0d cnt16=%0d required 0 32", c2, c0);
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_rows();
        test_msb_stall();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
        $finish;
    end

endmodule
